seq_det_stream_ctrl: RTL



---
 rtl/seq_det_stream_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/seq_det_stream_ctrl.sv
// Run controller for a serial sequence detector with Moore and Mealy outputs.
// Loads a stimulus word, resets the detector, streams the word MSB-first one
// bit per clock, counts Moore and Mealy hits with saturating counters, and
// flags any cycle where the Moore output disagrees with the Mealy output seen
// one cycle earlier.
//
// Handshake: start_i is accepted on a rising edge where ready_o is high; it is
// ignored in every other state (no queueing). done_o pulses for one cycle at
// the end of each run; counters and mismatch_o hold until the next accept.
module seq_det_stream_ctrl #(
  parameter int N_BITS = 40,
  parameter int CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [N_BITS-1:0] data_in_i,
  output logic              ready_o,
  output logic              det_rst_o,
  output logic              in_seq_o,
  input  logic              moore_y_i,
  input  logic              mealy_y_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  moore_cnt_o,
  output logic [CNT_W-1:0]  mealy_cnt_o,
  output logic              mismatch_o,
  output logic [2:0]        state_o
);

  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state_q;
  logic [N_BITS-1:0]   sr_q;
  logic [IDX_W-1:0]    idx_q;
  logic                mealy_q;
  logic [CNT_W-1:0]    moore_cnt_q;
  logic [CNT_W-1:0]    mealy_cnt_q;
  logic                mismatch_q;
  logic                ready_q;
  logic                busy_q;
  logic                done_q;
  logic                det_rst_q;
  logic                in_seq_q;

  logic [CNT_W-1:0]    moore_cnt_d;
  logic [CNT_W-1:0]    mealy_cnt_d;
  logic                moore_smp_d;

  // Saturating increments and the Moore sampling window (RUN after its first
  // cycle, plus DRAIN, which catches the response to the final bit).
  always_comb begin
    moore_cnt_d = moore_cnt_q;
    mealy_cnt_d = mealy_cnt_q;
    moore_smp_d = 1'b0;
    if (moore_cnt_q != CNT_MAX) moore_cnt_d = moore_cnt_q + CNT_W'(1);
    if (mealy_cnt_q != CNT_MAX) mealy_cnt_d = mealy_cnt_q + CNT_W'(1);
    if ((state_q == RUN && idx_q != '0) || state_q == DRAIN) moore_smp_d = 1'b1;
  end

  // Run sequencer: state, shift register, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      idx_q       <= '0;
      mealy_q     <= 1'b0;
      moore_cnt_q <= '0;
      mealy_cnt_q <= '0;
      mismatch_q  <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      det_rst_q   <= 1'b0;
      in_seq_q    <= 1'b0;
    end else begin
      if (moore_smp_d) begin
        if (moore_y_i) moore_cnt_q <= moore_cnt_d;
        if (moore_y_i != mealy_q) mismatch_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            sr_q        <= data_in_i;
            moore_cnt_q <= '0;
            mealy_cnt_q <= '0;
            mismatch_q  <= 1'b0;
            mealy_q     <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
            det_rst_q   <= 1'b1;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          // The first bit is presented on the first RUN cycle.
          det_rst_q <= 1'b0;
          idx_q     <= '0;
          in_seq_q  <= sr_q[N_BITS-1];
          sr_q      <= sr_q << 1;
          state_q   <= RUN;
        end
        RUN: begin
          mealy_q <= mealy_y_i;
          if (mealy_y_i) mealy_cnt_q <= mealy_cnt_d;
          if (idx_q == LAST_IDX) begin
            in_seq_q <= 1'b0;
            state_q  <= DRAIN;
          end else begin
            idx_q    <= idx_q + IDX_W'(1);
            in_seq_q <= sr_q[N_BITS-1];
            sr_q     <= sr_q << 1;
          end
        end
        DRAIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o     = ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign det_rst_o   = det_rst_q;
  assign in_seq_o    = in_seq_q;
  assign moore_cnt_o = moore_cnt_q;
  assign mealy_cnt_o = mealy_cnt_q;
  assign mismatch_o  = mismatch_q;
  assign state_o     = state_q;

endmodule
